i2c_slave_ctl: RTL

I2C target (slave) byte engine, the responder end of the bus that the existing I2C master core drives. It resolves START and STOP conditions, matches a 7-bit address, shifts write bytes out to a local consumer and read bytes in from a local producer, and drives ACK/NACK. It connects to pads through the same `iobuf` open-drain pattern as the master: it outputs only enable-low controls and never drives a line high.

---
 rtl/i2c_slave_ctl_pkg.sv | 28 ++
 rtl/i2c_slave_ctl_filter.sv | 52 +++++
 rtl/i2c_slave_ctl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_ctl_pkg.sv
// Shared definitions for the I2C target byte engine.
//   slv_state_e   : byte-engine FSM states
//   GenCallAddr   : general-call address, never acknowledged
//   FilterLenMin/Max : legal bounds of the glitch-filter depth
//   addr_match()  : own-address compare that excludes the general call
package i2c_slave_ctl_pkg;

    typedef enum logic [2:0] {
        SlvIdle,
        SlvAddr,
        SlvAddrAck,
        SlvRx,
        SlvRxAck,
        SlvTx,
        SlvTxAck,
        SlvWaitStop
    } slv_state_e;

    localparam logic [6:0] GenCallAddr = 7'h00;

    localparam int unsigned FilterLenMin = 1;
    localparam int unsigned FilterLenMax = 15;

    function automatic logic addr_match(input logic [6:0] rx_addr, input logic [6:0] own_addr);
        return (rx_addr == own_addr) && (rx_addr != GenCallAddr);
    endfunction

endpackage

// File: rtl/i2c_slave_ctl_filter.sv
// Pad-input conditioner: 2-flop synchroniser followed by a stable-count glitch filter.
// The filtered value only follows the synchronised input after it has differed for
// FILTER_LEN consecutive cycles, so pad-to-edge latency is 2 + FILTER_LEN cycles.
//   clk, rst_n : system clock, async active-low reset
//   din        : raw asynchronous pad value
//   dout       : filtered level (resets high, the idle bus level)
//   rise, fall : 1-cycle pulses, coincident with the dout update
module i2c_slave_ctl_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // 4-bit counter covers the full legal depth range of 1..15.
    localparam logic [3:0] CntMax = 4'(FILTER_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            dout    <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            rise    <= 1'b0;
            fall    <= 1'b0;
            if (sync2_q == dout) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                cnt_q <= '0;
                dout  <= sync2_q;
                rise  <= sync2_q;
                fall  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_ctl.sv
// I2C target (slave) byte engine. Detects START/STOP, matches a 7-bit address,
// delivers write bytes to a consumer, fetches read bytes from a producer and drives
// ACK/NACK. Pads are open-drain: outputs are enable-low and never drive high.
//   i_sysclk, i_reset_n      : system clock (>= 20x SCL), async active-low reset
//   i_enable                 : low forces idle and releases both lines
//   i_slave_addr             : own address, latched at START
//   i_scl, i_sda             : asynchronous pad inputs
//   o_scl_oen, o_sda_oen     : 0 pulls the line low, 1 releases it
//   o_rx_data, o_rx_valid    : received write byte and its 1-cycle strobe
//   o_tx_req                 : 1-cycle request for the next read byte
//   i_tx_data, i_tx_valid    : read byte from the producer
//   o_rw, o_busy             : latched R/W bit, addressed flag
//   o_start, o_stop, o_nack_rcvd : 1-cycle bus event pulses
// Build option: define I2C_SLV_STRETCH_EN to enable clock stretching while a read
// byte is late and after each received byte; otherwise o_scl_oen is tied high and
// a late read byte is sent as 8'hFF.
module i2c_slave_ctl
    import i2c_slave_ctl_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       i_sysclk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic [6:0] i_slave_addr,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl_oen,
    output logic       o_sda_oen,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_tx_req,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_rw,
    output logic       o_busy,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_nack_rcvd
);

    logic scl_filt, scl_rise, scl_fall;
    logic sda_filt, sda_rise, sda_fall;

    i2c_slave_ctl_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (i_sysclk),
        .rst_n (i_reset_n),
        .din   (i_scl),
        .dout  (scl_filt),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_slave_ctl_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (i_sysclk),
        .rst_n (i_reset_n),
        .din   (i_sda),
        .dout  (sda_filt),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_cond, stop_cond;
    assign start_cond = sda_fall & scl_filt;
    assign stop_cond  = sda_rise & scl_filt;

    slv_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       full_q, full_d;         // 8 bits of the current byte have been clocked
    logic [7:0] shift_q, shift_d;
    logic [6:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oen_q, sda_oen_d;
    logic       load_pend_q, load_pend_d; // in TX, waiting for the load point
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       nack_q, nack_d;
    logic       tx_point;                // load point reached this cycle
`ifdef I2C_SLV_STRETCH_EN
    logic       scl_oen_q, scl_oen_d;
    logic       stretch_q, stretch_d;    // holding SCL low for a late read byte
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        rx_data_d   = rx_data_q;
        sda_oen_d   = sda_oen_q;
        load_pend_d = load_pend_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        nack_d      = 1'b0;
        tx_point    = 1'b0;
`ifdef I2C_SLV_STRETCH_EN
        scl_oen_d   = scl_oen_q;
        stretch_d   = stretch_q;
`endif

        if (!i_enable || stop_cond || start_cond) begin
            // Common release for disable, STOP and (repeated) START.
            sda_oen_d   = 1'b1;
            load_pend_d = 1'b0;
            cnt_d       = '0;
            full_d      = 1'b0;
`ifdef I2C_SLV_STRETCH_EN
            scl_oen_d   = 1'b1;
            stretch_d   = 1'b0;
`endif
            if (!i_enable) begin
                state_d = SlvIdle;
                busy_d  = 1'b0;
            end else if (stop_cond) begin
                // STOP wins over a coincident START.
                state_d = SlvIdle;
                busy_d  = 1'b0;
                stop_d  = 1'b1;
            end else begin
                // busy is kept until the re-address result.
                state_d = SlvAddr;
                start_d = 1'b1;
                addr_d  = i_slave_addr;
            end
        end else begin
            unique case (state_q)
                SlvIdle, SlvWaitStop: begin
                end
                SlvAddr, SlvRx: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_filt};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) full_d = 1'b1;
                    end
                    if (scl_fall && full_q) begin
                        full_d = 1'b0;
                        cnt_d  = '0;
                        if (state_q == SlvRx) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_oen_d  = 1'b0;
                            state_d    = SlvRxAck;
`ifdef I2C_SLV_STRETCH_EN
                            scl_oen_d  = 1'b0;
`endif
                        end else if (addr_match(shift_q[7:1], addr_q)) begin
                            state_d   = SlvAddrAck;
                            busy_d    = 1'b1;
                            rw_d      = shift_q[0];
                            tx_req_d  = shift_q[0];
                            sda_oen_d = 1'b0;
                        end else begin
                            state_d = SlvWaitStop;
                            busy_d  = 1'b0;
                        end
                    end
                end
                SlvAddrAck: begin
                    if (scl_fall) begin
                        sda_oen_d = 1'b1;
                        cnt_d     = '0;
                        if (rw_q) tx_point = 1'b1;
                        else      state_d  = SlvRx;
                    end
                end
                SlvRxAck: begin
`ifdef I2C_SLV_STRETCH_EN
                    // rx_valid is already out; let SCL go.
                    if (!scl_oen_q) scl_oen_d = 1'b1;
`endif
                    if (scl_fall) begin
                        sda_oen_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = SlvRx;
                    end
                end
                SlvTx: begin
                    if (load_pend_q) begin
                        tx_point = scl_fall;
`ifdef I2C_SLV_STRETCH_EN
                        if (stretch_q) tx_point = 1'b1;
`endif
                    end else begin
`ifdef I2C_SLV_STRETCH_EN
                        // Release SCL one cycle after a stretched load.
                        if (!scl_oen_q) scl_oen_d = 1'b1;
`endif
                        if (scl_rise) begin
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_q == 3'd7) full_d = 1'b1;
                        end
                        if (scl_fall) begin
                            if (full_q) begin
                                full_d    = 1'b0;
                                sda_oen_d = 1'b1;
                                state_d   = SlvTxAck;
                            end else begin
                                shift_d   = {shift_q[6:0], 1'b0};
                                sda_oen_d = shift_q[6];
                            end
                        end
                    end
                end
                SlvTxAck: begin
                    if (scl_rise) begin
                        if (!sda_filt) begin
                            tx_req_d    = 1'b1;
                            load_pend_d = 1'b1;
                            state_d     = SlvTx;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = SlvWaitStop;
                        end
                    end
                end
                default: state_d = SlvIdle;
            endcase

            if (tx_point) begin
                state_d = SlvTx;
                cnt_d   = '0;
                full_d  = 1'b0;
`ifdef I2C_SLV_STRETCH_EN
                if (i_tx_valid) begin
                    shift_d     = i_tx_data;
                    sda_oen_d   = i_tx_data[7];
                    load_pend_d = 1'b0;
                    stretch_d   = 1'b0;
                end else begin
                    sda_oen_d   = 1'b1;
                    load_pend_d = 1'b1;
                    stretch_d   = 1'b1;
                    scl_oen_d   = 1'b0;
                end
`else
                shift_d     = i_tx_valid ? i_tx_data : 8'hFF;
                sda_oen_d   = i_tx_valid ? i_tx_data[7] : 1'b1;
                load_pend_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= SlvIdle;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            shift_q     <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= '0;
            sda_oen_q   <= 1'b1;
            load_pend_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            sda_oen_q   <= sda_oen_d;
            load_pend_q <= load_pend_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            nack_q      <= nack_d;
        end
    end

`ifdef I2C_SLV_STRETCH_EN
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scl_oen_q <= 1'b1;
            stretch_q <= 1'b0;
        end else begin
            scl_oen_q <= scl_oen_d;
            stretch_q <= stretch_d;
        end
    end
    assign o_scl_oen = scl_oen_q;
`else
    assign o_scl_oen = 1'b1;
`endif

    assign o_sda_oen   = sda_oen_q;
    assign o_rx_data   = rx_data_q;
    assign o_rx_valid  = rx_valid_q;
    assign o_tx_req    = tx_req_q;
    assign o_rw        = rw_q;
    assign o_busy      = busy_q;
    assign o_start     = start_q;
    assign o_stop      = stop_q;
    assign o_nack_rcvd = nack_q;

endmodule
